// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// ALU operation codes, datapath mux selects and branch-condition helpers.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC, S_UPPER, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
    ALU_SLT  = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9
  } alu_op_t;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCB_RS2   = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_FOUR  = 2'd2;
  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd4;

  function automatic logic branch_take(input logic [2:0] f3, input logic zero,
                                       input logic lt, input logic ltu);
    case (f3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // Signed/unsigned compares exist only in the full branch set.
  function automatic logic branch_legal(input logic [2:0] f3, input logic full);
    case (f3)
      3'b000, 3'b001:                 return 1'b1;
      3'b100, 3'b101, 3'b110, 3'b111: return full;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation select: forced ADD/SUB for address and compare
// cycles, otherwise decoded from funct3/funct7 of an R- or I-type instruction.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       is_rtype,
  input  logic       force_add,
  input  logic       force_sub,
  output logic [3:0] alucontrol
);

  alu_op_t alu_op;

  // funct7 selects SUB only for R-type; for shifts it selects SRA in both forms.
  always_comb begin
    alu_op = ALU_ADD;
    if (force_add) begin
      alu_op = ALU_ADD;
    end else if (force_sub) begin
      alu_op = ALU_SUB;
    end else begin
      case (funct3)
        3'b000:  alu_op = (is_rtype && funct7) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = funct7 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

  assign alucontrol = alu_op;

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the shared datapath's mux selects, enables and the sticky trap flag.
module multicycle_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit BRANCH_FULL = 1'b1,
  parameter bit MEM_WAIT    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] alucontrol,
  output logic [1:0] resultsrc,
  output logic [2:0] immsrc,
  output logic       regwrite,
  output logic       illegal
);

  if (XLEN != 32) begin : g_xlen_check
    $error("multicycle_ctrl_unit supports RV32 only");
  end

  state_t state, next_state;
  logic   ready, br_ok, take;
  logic   is_rtype, force_add, force_sub;

  assign ready = MEM_WAIT ? mem_ready : 1'b1;
  assign br_ok = branch_legal(funct3, BRANCH_FULL);
  assign take  = branch_take(funct3, zero, lt, ltu);

  // illegal is raised on the transition into TRAP so it is visible for the whole trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RESET;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_TRAP) illegal <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RESET:    next_state = S_FETCH;
      S_FETCH:    if (ready) next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI, OP_AUIPC:  next_state = S_UPPER;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ready) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: if (ready) next_state = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_JALRPC, S_UPPER: next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = br_ok ? S_FETCH : S_TRAP;
      S_JALR:     next_state = S_JALRPC;
      default:    next_state = S_TRAP;
    endcase
  end

  // Moore decode of state; only FETCH strobes and the branch PC load look at inputs.
  always_comb begin
    mem_req   = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RS2;
    resultsrc = RES_ALUOUT;
    immsrc    = IMM_I;
    regwrite  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
        irwrite   = ready;
        pcwrite   = ready;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        immsrc  = IMM_B;
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        immsrc  = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        resultsrc = RES_MEM;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        adrsrc   = 1'b1;
      end
      S_EXECR: alusrca = SRCA_RS1;
      S_EXECI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
      end
      S_ALUWB: regwrite = 1'b1;
      S_BRANCH: begin
        alusrca = SRCA_RS1;
        pcwrite = br_ok && take;
      end
      S_JAL, S_JALRPC: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_FOUR;
        pcwrite = 1'b1;
      end
      S_JALR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
      end
      S_UPPER: begin
        alusrca = (op == OP_AUIPC) ? SRCA_OLDPC : SRCA_RS1;
        alusrcb = SRCB_IMM;
        immsrc  = IMM_U;
      end
      default: ;
    endcase
  end

  assign is_rtype  = (state == S_EXECR);
  assign force_sub = (state == S_BRANCH);
  assign force_add = !(state == S_EXECR || state == S_EXECI || state == S_BRANCH);

  alu_decoder u_alu_decoder (
    .funct3    (funct3),
    .funct7    (funct7),
    .is_rtype  (is_rtype),
    .force_add (force_add),
    .force_sub (force_sub),
    .alucontrol(alucontrol)
  );

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: a full-feature instance plus a
// BEQ/BNE-only, no-wait-state instance, checked cycle by cycle on packed outputs.
module tb_multicycle_ctrl_unit;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  logic [19:0] a_out, b_out;
  int checks = 0;
  int failures = 0;
  logic [19:0] exp_fetch_go, exp_fetch_stall, exp_decode, exp_aluwb, exp_trap;

  always #5 clk = ~clk;

  multicycle_ctrl_unit dut_a (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(a_out[19]), .memwrite(a_out[18]), .irwrite(a_out[17]), .pcwrite(a_out[16]),
    .adrsrc(a_out[15]), .alusrca(a_out[14:13]), .alusrcb(a_out[12:11]),
    .alucontrol(a_out[10:7]), .resultsrc(a_out[6:5]), .immsrc(a_out[4:2]),
    .regwrite(a_out[1]), .illegal(a_out[0])
  );

  multicycle_ctrl_unit #(.BRANCH_FULL(1'b0), .MEM_WAIT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(b_out[19]), .memwrite(b_out[18]), .irwrite(b_out[17]), .pcwrite(b_out[16]),
    .adrsrc(b_out[15]), .alusrca(b_out[14:13]), .alusrcb(b_out[12:11]),
    .alucontrol(b_out[10:7]), .resultsrc(b_out[6:5]), .immsrc(b_out[4:2]),
    .regwrite(b_out[1]), .illegal(b_out[0])
  );

  // Field order: mem_req memwrite irwrite pcwrite adrsrc alusrca alusrcb alucontrol resultsrc immsrc regwrite illegal
  function automatic logic [19:0] ov(input int mreq, input int mw, input int irw, input int pcw,
                                     input int adr, input int sa, input int sb, input int alu,
                                     input int res, input int imm, input int rw, input int ill);
    return {mreq[0], mw[0], irw[0], pcw[0], adr[0], sa[1:0], sb[1:0], alu[3:0],
            res[1:0], imm[2:0], rw[0], ill[0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [19:0] actual, input logic [19:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%05h expected=%05h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic z, input logic l, input logic lu, input logic rdy);
    @(negedge clk);
    op = o; funct3 = f3; funct7 = f7; zero = z; lt = l; ltu = lu; mem_ready = rdy;
    #1;
  endtask

  task automatic step(input logic [6:0] o, input logic rdy, input string tag, input logic [19:0] expected);
    applyStimulus(o, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    checkOutput(tag, a_out, expected);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput({tag, "_async_a"}, a_out, 20'h0);
    checkOutput({tag, "_async_b"}, b_out, 20'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput({tag, "_state"}, a_out, 20'h0);
  endtask

  task automatic run_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input int alu, input string tag);
    applyStimulus(o, f3, f7, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput({tag, "_fetch"}, a_out, exp_fetch_go);
    applyStimulus(o, f3, f7, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput({tag, "_decode"}, a_out, exp_decode);
    applyStimulus(o, f3, f7, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput({tag, "_exec"}, a_out, ov(0, 0, 0, 0, 0, 2, (o == OP_RTYPE) ? 0 : 1, alu, 0, 0, 0, 0));
    applyStimulus(o, f3, f7, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput({tag, "_wb"}, a_out, exp_aluwb);
  endtask

  task automatic run_branch(input logic [2:0] f3, input logic z, input logic l, input logic lu,
                            input int pcw, input string tag);
    applyStimulus(OP_BRANCH, f3, 1'b0, z, l, lu, 1'b1);
    checkOutput({tag, "_fetch"}, a_out, exp_fetch_go);
    applyStimulus(OP_BRANCH, f3, 1'b0, z, l, lu, 1'b1);
    checkOutput({tag, "_decode"}, a_out, exp_decode);
    applyStimulus(OP_BRANCH, f3, 1'b0, z, l, lu, 1'b1);
    checkOutput({tag, "_branch"}, a_out, ov(0, 0, 0, pcw, 0, 2, 0, 1, 0, 0, 0, 0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_fetch_go    = ov(1, 0, 1, 1, 0, 0, 2, 0, 2, 0, 0, 0);
    exp_fetch_stall = ov(1, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0);
    exp_decode      = ov(0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0);
    exp_aluwb       = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    exp_trap        = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    $display("[TB] start");

    do_reset("reset0");
    step(OP_RTYPE, 1'b0, "fetch_stall0", exp_fetch_stall);
    step(OP_RTYPE, 1'b0, "fetch_stall1", exp_fetch_stall);
    do_reset("rst_mid_fetch");
    step(OP_RTYPE, 1'b0, "post_rst_stall", exp_fetch_stall);

    run_alu(OP_RTYPE, 3'b000, 1'b0, 0, "add");
    run_alu(OP_RTYPE, 3'b000, 1'b1, 1, "sub");
    run_alu(OP_ITYPE, 3'b000, 1'b1, 0, "addi_f7");
    run_alu(OP_RTYPE, 3'b101, 1'b1, 9, "sra");
    run_alu(OP_ITYPE, 3'b101, 1'b0, 8, "srli");
    run_alu(OP_RTYPE, 3'b010, 1'b0, 5, "slt");
    run_alu(OP_ITYPE, 3'b011, 1'b0, 6, "sltiu");
    run_alu(OP_RTYPE, 3'b111, 1'b0, 2, "and");
    run_alu(OP_ITYPE, 3'b110, 1'b0, 3, "ori");
    run_alu(OP_RTYPE, 3'b100, 1'b0, 4, "xor");
    run_alu(OP_RTYPE, 3'b001, 1'b0, 7, "sll");

    step(OP_LOAD, 1'b1, "lw_fetch", exp_fetch_go);
    step(OP_LOAD, 1'b1, "lw_decode", exp_decode);
    step(OP_LOAD, 1'b1, "lw_memadr", ov(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(OP_LOAD, 1'b0, "lw_wait", ov(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(OP_LOAD, 1'b1, "lw_done", ov(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(OP_LOAD, 1'b0, "lw_memwb", ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    step(OP_LOAD, 1'b0, "lw_next", exp_fetch_stall);

    step(OP_STORE, 1'b1, "sw_fetch", exp_fetch_go);
    step(OP_STORE, 1'b1, "sw_decode", exp_decode);
    step(OP_STORE, 1'b1, "sw_memadr", ov(0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0));
    step(OP_STORE, 1'b1, "sw_memwrite", ov(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(OP_STORE, 1'b0, "sw_next", exp_fetch_stall);

    run_branch(3'b110, 1'b0, 1'b0, 1'b1, 1, "bltu_t");
    run_branch(3'b110, 1'b0, 1'b0, 1'b0, 0, "bltu_nt");
    run_branch(3'b000, 1'b1, 1'b0, 1'b0, 1, "beq_t");
    run_branch(3'b001, 1'b1, 1'b0, 1'b0, 0, "bne_nt");
    run_branch(3'b100, 1'b0, 1'b1, 1'b0, 1, "blt_t");
    run_branch(3'b101, 1'b0, 1'b0, 1'b0, 1, "bge_t");
    run_branch(3'b111, 1'b0, 1'b0, 1'b1, 0, "bgeu_nt");

    step(OP_JAL, 1'b1, "jal_fetch", exp_fetch_go);
    step(OP_JAL, 1'b1, "jal_decode", exp_decode);
    step(OP_JAL, 1'b1, "jal_pc", ov(0, 0, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0));
    step(OP_JAL, 1'b1, "jal_wb", exp_aluwb);
    step(OP_JALR, 1'b1, "jalr_fetch", exp_fetch_go);
    step(OP_JALR, 1'b1, "jalr_decode", exp_decode);
    step(OP_JALR, 1'b1, "jalr_adr", ov(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
    step(OP_JALR, 1'b1, "jalr_pc", ov(0, 0, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0));
    step(OP_JALR, 1'b1, "jalr_wb", exp_aluwb);
    step(OP_LUI, 1'b1, "lui_fetch", exp_fetch_go);
    step(OP_LUI, 1'b1, "lui_decode", exp_decode);
    step(OP_LUI, 1'b1, "lui_upper", ov(0, 0, 0, 0, 0, 2, 1, 0, 0, 4, 0, 0));
    step(OP_LUI, 1'b1, "lui_wb", exp_aluwb);
    step(OP_AUIPC, 1'b1, "auipc_fetch", exp_fetch_go);
    step(OP_AUIPC, 1'b1, "auipc_decode", exp_decode);
    step(OP_AUIPC, 1'b1, "auipc_upper", ov(0, 0, 0, 0, 0, 1, 1, 0, 0, 4, 0, 0));
    step(OP_AUIPC, 1'b1, "auipc_wb", exp_aluwb);

    // Reduced instance: no wait states, so it fetches while the full one stalls.
    do_reset("reset_b");
    applyStimulus(OP_BRANCH, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("a_stall_nowait", a_out, exp_fetch_stall);
    checkOutput("b_fetch_nowait", b_out, exp_fetch_go);
    applyStimulus(OP_BRANCH, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("b_decode", b_out, exp_decode);
    applyStimulus(OP_BRANCH, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("b_bltu_illegal", b_out, ov(0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0));
    checkOutput("a_still_stalled", a_out, exp_fetch_stall);
    applyStimulus(OP_BRANCH, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(OP_BRANCH, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("b_trap", b_out, exp_trap);

    do_reset("reset_f3");
    run_branch(3'b010, 1'b1, 1'b1, 1'b1, 0, "b010_illegal");
    applyStimulus(OP_BRANCH, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(OP_BRANCH, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("b010_trap", a_out, exp_trap);

    do_reset("reset_op0");
    step(7'b0000000, 1'b1, "op0_fetch", exp_fetch_go);
    step(7'b0000000, 1'b1, "op0_decode", exp_decode);
    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(OP_RTYPE, 1'b1, "op0_trap_sticky", exp_trap);

    do_reset("reset_final");
    step(OP_RTYPE, 1'b1, "final_fetch", exp_fetch_go);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
